// File: rtl/free_list_pkg.sv
// Rename-wide types shared by the free list, ROB, rename and regfile.
// Physical register width and free-list capacity live here.
package rv32i_types;

  localparam int PHYS_REG_BITS   = 6;
  localparam int ARCH_REGS       = 32;
  localparam int FREE_LIST_DEPTH = 32;
  localparam int FL_CNT_BITS     = $clog2(FREE_LIST_DEPTH) + 1;

  typedef logic [PHYS_REG_BITS-1:0] preg_t;
  typedef logic [FL_CNT_BITS-1:0]   fl_cnt_t;

endpackage

// File: rtl/free_list_if.sv
// Rename <-> free list bundle: allocation, commit return and flush.
// The rename/ROB side is master; the free list is slave.
interface free_list_if;
  import rv32i_types::*;

  logic    alloc_req;
  logic    alloc_valid;
  preg_t   alloc_preg;
  logic    commit_req;
  preg_t   commit_old_preg;
  logic    flush;
  fl_cnt_t count;
  logic    empty;

  modport master (
    output alloc_req,
    output commit_req,
    output commit_old_preg,
    output flush,
    input  alloc_valid,
    input  alloc_preg,
    input  count,
    input  empty
  );

  modport slave (
    input  alloc_req,
    input  commit_req,
    input  commit_old_preg,
    input  flush,
    output alloc_valid,
    output alloc_preg,
    output count,
    output empty
  );

endinterface

// File: rtl/free_list.sv
// Circular free list of physical registers with a speculative head.
// Flush rolls the speculative head back to the retire head.
module free_list #(
  parameter int PHYS_REG_BITS = rv32i_types::PHYS_REG_BITS,
  parameter int DEPTH         = rv32i_types::FREE_LIST_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_req,
  output logic                     alloc_valid,
  output logic [PHYS_REG_BITS-1:0] alloc_preg,
  input  logic                     commit_req,
  input  logic [PHYS_REG_BITS-1:0] commit_old_preg,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int IW   = $clog2(DEPTH);
  localparam int PW   = IW + 1;
  localparam int BASE = rv32i_types::ARCH_REGS;

  typedef logic [PW-1:0] ptr_t;

  logic [PHYS_REG_BITS-1:0] r_mem [DEPTH];

  ptr_t r_spec_head;
  ptr_t r_retire_head;
  ptr_t r_tail;

  ptr_t          w_spec_nxt;
  ptr_t          w_retire_nxt;
  ptr_t          w_tail_nxt;
  ptr_t          w_count;
  logic [IW-1:0] w_sidx;
  logic [IW-1:0] w_tidx;
  logic          w_same_wrap;
  logic          w_empty;
  logic          w_full;
  logic          w_grant;
  logic          w_enq;

  // Index wraps at DEPTH-1 and flips the wrap bit; works for any DEPTH.
  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t n;
    if (p[IW-1:0] == IW'(DEPTH - 1))
      n = {~p[PW-1], {IW{1'b0}}};
    else
      n = p + PW'(1);
    return n;
  endfunction

  assign w_sidx      = r_spec_head[IW-1:0];
  assign w_tidx      = r_tail[IW-1:0];
  assign w_same_wrap = r_spec_head[IW] == r_tail[IW];

  assign w_empty = r_tail == r_spec_head;
  assign w_full  = !w_same_wrap && (w_tidx == w_sidx);

  assign w_count = w_same_wrap
    ? PW'(w_tidx) - PW'(w_sidx)
    : PW'(DEPTH) + PW'(w_tidx) - PW'(w_sidx);

  assign w_grant = alloc_req && !w_empty && !flush;
  assign w_enq   = commit_req
    && (commit_old_preg != '0)
    && !w_full;

  assign w_retire_nxt = commit_req
    ? ptr_inc(r_retire_head)
    : r_retire_head;

  assign w_tail_nxt = w_enq ? ptr_inc(r_tail) : r_tail;

  always_comb begin
    w_spec_nxt = r_spec_head;
    unique case (1'b1)
      flush:   w_spec_nxt = w_retire_nxt;
      w_grant: w_spec_nxt = ptr_inc(r_spec_head);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_spec_head   <= '0;
      r_retire_head <= '0;
      r_tail        <= {1'b1, {IW{1'b0}}};
    end else begin
      r_spec_head   <= w_spec_nxt;
      r_retire_head <= w_retire_nxt;
      r_tail        <= w_tail_nxt;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    always_ff @(posedge clk) begin
      if (rst)
        r_mem[g] <= PHYS_REG_BITS'(BASE + g);
      else if (w_enq && (w_tidx == IW'(g)))
        r_mem[g] <= commit_old_preg;
    end
  end

  // Reset values are shown while rst is held, before any edge lands.
  assign alloc_valid = rst ? 1'b1 : !w_empty;
  assign empty       = rst ? 1'b0 : w_empty;
  assign count       = rst ? PW'(DEPTH) : w_count;
  assign alloc_preg  = rst
    ? PHYS_REG_BITS'(BASE)
    : r_mem[w_sidx];

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(commit_req && commit_old_preg != '0 && w_full))
        else $error("free_list: enqueue while full dropped");
      assert (!(commit_req && !w_grant
                && r_retire_head == r_spec_head))
        else $error("free_list: retire_head passed spec_head");
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: stimulus queues expectations,
// a negedge monitor pops and compares every active cycle.
module tb_free_list;
  import rv32i_types::*;

  localparam int D = FREE_LIST_DEPTH;

  typedef struct {
    int cnt;
    bit g;
    int preg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  free_list_if fl();

  free_list #(
    .PHYS_REG_BITS(PHYS_REG_BITS),
    .DEPTH        (D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req      (fl.alloc_req),
    .alloc_valid    (fl.alloc_valid),
    .alloc_preg     (fl.alloc_preg),
    .commit_req     (fl.commit_req),
    .commit_old_preg(fl.commit_old_preg),
    .flush          (fl.flush),
    .count          (fl.count),
    .empty          (fl.empty)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  exp_t exp_q[$];
  int   L[$];
  int   H[$];
  int   k;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d, expected %0d",
               phase, nm, got, exp);
    end
  endtask

  task automatic model_init();
    L.delete();
    H.delete();
    for (int i = 0; i < D; i++) L.push_back(32 + i);
    for (int i = 1; i < 32; i++) H.push_back(i);
    k = 0;
  endtask

  task automatic idle();
    fl.alloc_req       = 1'b0;
    fl.commit_req      = 1'b0;
    fl.commit_old_preg = '0;
    fl.flush           = 1'b0;
  endtask

  task automatic do_reset(int n);
    rst                = 1'b1;
    fl.alloc_req       = 1'b1;
    fl.commit_req      = 1'b1;
    fl.commit_old_preg = PHYS_REG_BITS'(13);
    fl.flush           = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_valid", 32'(fl.alloc_valid), 1);
      chk("rst_preg", 32'(fl.alloc_preg), 32);
      chk("rst_count", 32'(fl.count), 32);
      chk("rst_empty", 32'(fl.empty), 0);
    end
    rst = 1'b0;
    idle();
    model_init();
  endtask

  task automatic step(bit a, bit c, int old, bit f);
    exp_t e;
    bit   g;
    int   fr;
    g      = a && !f && (L.size() - k > 0);
    e.cnt  = L.size() - k;
    e.g    = g;
    e.preg = g ? L[k] : 0;
    exp_q.push_back(e);
    fl.alloc_req       = a;
    fl.commit_req      = c;
    fl.commit_old_preg = PHYS_REG_BITS'(old);
    fl.flush           = f;
    @(posedge clk);
    #1;
    if (g) k++;
    if (c) begin
      fr = L.pop_front();
      k--;
      H.push_back(fr);
      if (old != 0) L.push_back(old);
    end
    if (f) k = 0;
    idle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic gnt;
    if (rst === 1'b0 && exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      gnt = fl.alloc_req & fl.alloc_valid & ~fl.flush;
      chk("count", 32'(fl.count), e.cnt);
      chk("empty", 32'(fl.empty), 32'(e.cnt == 0));
      chk("grant", 32'(gnt), 32'(e.g));
      if (e.g) chk("alloc_preg", 32'(fl.alloc_preg), e.preg);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    bit c;
    bit f;
    int old;
    int idx;
    idle();
    rst = 1'b1;

    phase = "reset";
    do_reset(2);
    chk("post_rst_count", 32'(fl.count), 32);

    phase = "drain";
    repeat (D) step(1, 0, 0, 0);
    chk("drain_count", 32'(fl.count), 0);
    chk("drain_empty", 32'(fl.empty), 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    phase = "refill_wrap";
    step(0, 1, 40, 0);
    step(0, 1, 41, 0);
    chk("refill_count", 32'(fl.count), 2);
    chk("refill_head", 32'(fl.alloc_preg), 40);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    phase = "flush";
    do_reset(1);
    repeat (5) step(1, 0, 0, 0);
    step(0, 1, 7, 0);
    step(0, 1, 9, 0);
    step(0, 0, 0, 1);
    chk("flush_count", 32'(fl.count), 32);
    chk("flush_head", 32'(fl.alloc_preg), 34);
    step(1, 0, 0, 0);

    phase = "alloc_commit";
    do_reset(1);
    repeat (22) step(1, 0, 0, 0);
    chk("pre_count", 32'(fl.count), 10);
    step(1, 1, 5, 0);
    chk("same_cycle_count", 32'(fl.count), 10);
    repeat (10) step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    phase = "flush_alloc_commit";
    do_reset(1);
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, 3, 1);
    chk("fac_count", 32'(fl.count), 32);
    chk("fac_head", 32'(fl.alloc_preg), 33);
    step(1, 0, 0, 0);

    phase = "random";
    do_reset(1);
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        phase = "random_rst";
        do_reset(1);
        phase = "random";
      end
      a   = $urandom_range(0, 99) < 60;
      c   = (k > 0) && ($urandom_range(0, 99) < 45);
      f   = $urandom_range(0, 99) < 3;
      old = 0;
      if (c && H.size() > 0 && $urandom_range(0, 15) != 0) begin
        idx = $urandom_range(0, H.size() - 1);
        old = H[idx];
        H.delete(idx);
      end
      step(a, c, old, f);
      if (n_fail > 20) break;
    end

    phase = "end";
    step(0, 0, 0, 0);
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 The block SHALL be parameterised with PHYS_REG_BITS, default 6, the physical register index width (64 physical registers).
REQ-002 The block SHALL be parameterised with DEPTH, default 32, the free-list capacity (physical registers minus architectural registers).
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset, on ports named exactly as below.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- alloc_req  input  1  rename stage requests one physical register this cycle.
- alloc_valid  output  1  high when the list is non-empty, so a request can be granted this cycle.
- alloc_preg  output  PHYS_REG_BITS  physical register at the speculative head; meaningful only when alloc_valid=1.
- commit_req  input  1  ROB commits one instruction with rd!=x0.
- commit_old_preg  input  PHYS_REG_BITS  previous mapping of the committed rd, returned to the list.
- flush  input  1  mispredict recovery; discards all speculative allocations.
- count  output  $clog2(DEPTH)+1  number of speculatively free entries.
- empty  output  1  count==0.

Function
REQ-004 Storage SHALL be a circular array of DEPTH entries, each PHYS_REG_BITS wide.
REQ-005 The block SHALL keep three pointers of $clog2(DEPTH)+1 bits (MSB is the wrap bit): spec_head, retire_head and tail.
REQ-006 alloc_preg SHALL be the combinational read of entry[spec_head]; alloc_valid SHALL be !empty.
REQ-007 A grant occurs when alloc_req && alloc_valid && !flush; spec_head SHALL then increment by 1 at the next edge.
REQ-008 alloc_req while empty SHALL be ignored: no pointer move and no bypass from a same-cycle commit.
REQ-009 On commit_req, retire_head SHALL increment by 1, entry[tail] SHALL take commit_old_preg, and tail SHALL increment by 1, all at the next edge.
REQ-010 commit_old_preg==0 SHALL never be enqueued; in that case only retire_head advances.
REQ-011 A grant and a commit in the same cycle SHALL both take effect; count is unchanged.
REQ-012 On flush, spec_head SHALL take retire_head, including any same-cycle commit increment; a same-cycle alloc_req SHALL NOT be granted.
REQ-013 count SHALL equal tail minus spec_head, modulo 2*DEPTH. The list is full when the index bits are equal and the wrap bits differ; empty when the pointers are equal.
REQ-014 Pointer wrap from DEPTH-1 to 0 SHALL toggle the wrap bit, with no bubble.
REQ-015 An enqueue while full SHALL be dropped. A simulation-only assertion SHALL fire, as SHALL one for retire_head passing spec_head.
REQ-016 Physical registers handed out at alloc_preg SHALL appear in strict FIFO order of enqueue.

Reset
REQ-017 On rst, entry[i] SHALL become 32+i for i=0..DEPTH-1.
REQ-018 On rst, spec_head and retire_head SHALL become 0, and tail SHALL become DEPTH (wrap bit set, index 0), i.e. full.
REQ-019 While rst=1, the outputs SHALL be alloc_valid=1, alloc_preg=32, count=32, empty=0.
REQ-020 During reset cycles, alloc_req, commit_req and flush SHALL be ignored; rst wins over all.
REQ-021 Reset mid-operation SHALL fully restore the REQ-017/018 state in one cycle.

Structure
REQ-022 PHYS_REG_BITS, FREE_LIST_DEPTH and the typedef preg_t (logic [PHYS_REG_BITS-1:0]) SHALL live in rv32i_types; the rename, ROB and regfile blocks share them.
REQ-023 The block SHALL be a single module with no sub-module; pointer arithmetic is local.
REQ-024 The outputs SHALL have no combinational path from alloc_req, commit_req or flush.

Verification
REQ-025 Post-reset, 32 back-to-back allocations -> alloc_preg 32,33,...,63 in order; then empty=1, count=0, and a 33rd request is ignored.
REQ-026 From empty, commit 40, then commit 41 -> count=2; allocation returns 40, then 41, with wrap across index 31->0 correct.
REQ-027 Allocate 5 (32..36), commit 2 (old 7, 9), then flush -> spec_head = retire_head, count=32-2+2=32, and the next alloc_preg is 34.
REQ-028 Same-cycle alloc_req+commit_req at count=10 -> count stays 10, and the committed preg appears after the 9 older entries.
REQ-029 Same-cycle flush+alloc_req+commit_req -> no grant, retire_head+1 restored into spec_head, tail+1.
REQ-030 Random alloc/commit/flush for 10k cycles against a reference queue model -> the sequences match, no preg is live twice, and preg 0 is never issued.
